// File: rtl/match_ctrl.sv
// match_ctrl: rally/match sequencer sitting behind the 60 Hz physics engine.
// Gates the physics frame enable, keeps both scores, inserts a timed pause
// after each rally, declares the match winner and issues a one-cycle soft
// reset to physics whenever a match starts.
module match_ctrl #(
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned SCORE_W      = 4,
   parameter int unsigned PAUSE_FRAMES = 90,
   parameter int unsigned PAUSE_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               phys_valid,
   input  logic               phys_game_over,
   input  logic [1:0]         phys_winner,
   output logic               phys_en,
   output logic               phys_rst_n,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic [1:0]         state,
   output logic               rally_end,
   output logic [1:0]         match_winner
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] PLAY       = 2'd1;
   localparam logic [1:0] PAUSE      = 2'd2;
   localparam logic [1:0] MATCH_OVER = 2'd3;

   // A zero-length pause still costs one frame_tick.
   localparam logic [PAUSE_W-1:0] PAUSE_LOAD =
      (PAUSE_FRAMES == 0) ? PAUSE_W'(1) : PAUSE_W'(PAUSE_FRAMES);
   localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

   logic               start_prev;
   logic               go_seen;
   logic [PAUSE_W-1:0] pause_cnt;

   logic               start_rise;
   logic               accept;
   logic [SCORE_W-1:0] p1_inc;
   logic [SCORE_W-1:0] p2_inc;

   logic [1:0]         state_nxt;
   logic [SCORE_W-1:0] p1_nxt;
   logic [SCORE_W-1:0] p2_nxt;
   logic [1:0]         winner_nxt;
   logic [PAUSE_W-1:0] cnt_nxt;
   logic               go_nxt;
   logic               soft_rst_nxt;
   logic               rally_nxt;

   // Start edge detect, rally acceptance and candidate incremented scores.
   always_comb begin
      start_rise = start_btn & ~start_prev;
      accept     = (state == PLAY) & phys_valid & phys_game_over & ~go_seen;
      p1_inc     = score_p1 + SCORE_W'(1);
      p2_inc     = score_p2 + SCORE_W'(1);
   end

   // Next-state and next-value logic for the match sequencer.
   always_comb begin
      state_nxt    = state;
      p1_nxt       = score_p1;
      p2_nxt       = score_p2;
      winner_nxt   = match_winner;
      cnt_nxt      = pause_cnt;
      go_nxt       = go_seen;
      soft_rst_nxt = 1'b1;
      rally_nxt    = 1'b0;

      // A non-game-over result means physics has left the rally-over
      // condition, so the next game_over is a fresh rally end.
      if (phys_valid && !phys_game_over)
         go_nxt = 1'b0;

      case (state)
         IDLE, MATCH_OVER: begin
            if (start_rise) begin
               p1_nxt       = '0;
               p2_nxt       = '0;
               winner_nxt   = 2'd0;
               soft_rst_nxt = 1'b0;
               go_nxt       = 1'b0;
               state_nxt    = PLAY;
            end
         end
         PLAY: begin
            if (accept) begin
               go_nxt = 1'b1;
               if (phys_winner == 2'd1) begin
                  p1_nxt    = p1_inc;
                  rally_nxt = 1'b1;
                  if (p1_inc == WIN_VAL) begin
                     state_nxt  = MATCH_OVER;
                     winner_nxt = 2'd1;
                  end else begin
                     state_nxt = PAUSE;
                     cnt_nxt   = PAUSE_LOAD;
                  end
               end else if (phys_winner == 2'd2) begin
                  p2_nxt    = p2_inc;
                  rally_nxt = 1'b1;
                  if (p2_inc == WIN_VAL) begin
                     state_nxt  = MATCH_OVER;
                     winner_nxt = 2'd2;
                  end else begin
                     state_nxt = PAUSE;
                     cnt_nxt   = PAUSE_LOAD;
                  end
               end
            end
         end
         PAUSE: begin
            if (frame_tick) begin
               if (pause_cnt == PAUSE_W'(1)) begin
                  state_nxt = PLAY;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = pause_cnt - PAUSE_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers; phys_en samples the pre-transition state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         score_p1     <= '0;
         score_p2     <= '0;
         phys_en      <= 1'b0;
         phys_rst_n   <= 1'b1;
         rally_end    <= 1'b0;
         match_winner <= 2'd0;
         pause_cnt    <= '0;
         go_seen      <= 1'b0;
         start_prev   <= 1'b0;
      end else begin
         state        <= state_nxt;
         score_p1     <= p1_nxt;
         score_p2     <= p2_nxt;
         phys_en      <= frame_tick & (state == PLAY);
         phys_rst_n   <= soft_rst_nxt;
         rally_end    <= rally_nxt;
         match_winner <= winner_nxt;
         pause_cnt    <= cnt_nxt;
         go_seen      <= go_nxt;
         start_prev   <= start_btn;
      end
   end

endmodule
